fwd_lookup_ctrl: RTL and testbench

- Initiator side of the MAC address table interface: accepts per-ingress-port header descriptors (DA, SA), arbitrates between ports round-robin, and issues learn and read requests to the table.
- Turns the table response into a per-frame forwarding decision: unicast mask, flood mask, or drop.
- Sits between the ingress parsers and the switch fabric scheduler.

---
 rtl/fwd_lookup_pkg.sv | 22 ++
 rtl/fwd_lookup_ctrl_rr_arbiter.sv | 45 ++++
 rtl/fwd_lookup_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fwd_lookup_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_lookup_pkg.sv
// Purpose : shared types and constants for the forwarding lookup controller.
// Latency : n/a (package only).
// Backpressure: n/a. Exports state_t, MAC_WIDTH, IG_BIT, BCAST_ADDR, is_group().
package fwd_lookup_pkg;

  localparam int                  MAC_WIDTH  = 48;
  // Individual/group bit: LSB of the first transmitted octet.
  localparam int                  IG_BIT     = 40;
  localparam logic [MAC_WIDTH-1:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  function automatic logic is_group(input logic [MAC_WIDTH-1:0] addr);
    return addr[IG_BIT];
  endfunction

endpackage

// File: rtl/fwd_lookup_ctrl_rr_arbiter.sv
// Purpose : round-robin arbiter; searches upward from last grant + 1 with wrap.
// Latency : grant is combinational from i_req; pointer updates on i_advance.
// Backpressure: none; o_grant is zero when no request is present.
// Ports   : i_clk, i_rst, i_req[N], i_advance -> o_grant (one-hot), o_grant_idx.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] r_last;
  logic          w_found;
  int            w_k;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_k         = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(r_last) + 1 + i) % N;
      if (!w_found && i_req[w_k]) begin
        w_found          = 1'b1;
        o_grant[w_k]     = 1'b1;
        o_grant_idx      = IW'(w_k);
      end
    end
  end

  // Reset points at the top port so port 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= IW'(N - 1);
    end else if (i_advance && w_found) begin
      r_last <= o_grant_idx;
    end
  end

endmodule

// File: rtl/fwd_lookup_ctrl.sv
// Purpose : arbitrates ingress header descriptors, issues learn/read to the MAC
//           table and turns the reply into a unicast/flood/drop decision.
// Latency : accept -> ISSUE 1 cycle; ISSUE -> decision 1 cycle (group DA) or
//           up to LOOKUP_LATENCY+1 cycles (unicast DA).
// Backpressure: one descriptor in flight; decision held until fwd_ready_i,
//           req_ready_o stays low until the controller is back in IDLE.
// Ports   : req_* from parsers, learn_*/read_* to/from table, fwd_* to scheduler.
module fwd_lookup_ctrl
  import fwd_lookup_pkg::*;
#(
  parameter  int NUM_PORTS      = 4,
  parameter  int LOOKUP_LATENCY = 1,
  localparam int PW             = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req_valid_i,
  output logic [NUM_PORTS-1:0]           req_ready_o,
  input  logic [NUM_PORTS*MAC_WIDTH-1:0] req_dst_addr_i,
  input  logic [NUM_PORTS*MAC_WIDTH-1:0] req_src_addr_i,
  output logic                           learn_req_o,
  output logic [MAC_WIDTH-1:0]           learn_address_o,
  output logic [PW-1:0]                  learn_port_o,
  output logic                           read_req_o,
  output logic [MAC_WIDTH-1:0]           read_address_o,
  input  logic [PW-1:0]                  read_port_i,
  input  logic                           read_port_valid_i,
  output logic                           fwd_valid_o,
  input  logic                           fwd_ready_i,
  output logic [NUM_PORTS-1:0]           fwd_mask_o,
  output logic [PW-1:0]                  fwd_src_port_o,
  output logic                           fwd_drop_o
);

  localparam int CW = ($clog2(LOOKUP_LATENCY + 1) > 0) ? $clog2(LOOKUP_LATENCY + 1) : 1;

  state_t                 r_state, w_next;
  logic [MAC_WIDTH-1:0]   r_da, r_sa;
  logic [PW-1:0]          r_port;
  logic [CW-1:0]          r_cnt;
  logic [NUM_PORTS-1:0]   r_mask;
  logic                   r_drop;

  logic [NUM_PORTS-1:0]   w_grant;
  logic [PW-1:0]          w_gidx;
  logic                   w_accept;
  logic                   w_hit, w_miss;
  logic [MAC_WIDTH-1:0]   w_sel_da, w_sel_sa;
  logic [NUM_PORTS-1:0]   w_flood, w_onehot;

  rr_arbiter #(.N(NUM_PORTS), .IW(PW)) u_arb (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req_valid_i),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign w_sel_da = req_dst_addr_i[w_gidx*MAC_WIDTH +: MAC_WIDTH];
  assign w_sel_sa = req_src_addr_i[w_gidx*MAC_WIDTH +: MAC_WIDTH];
  assign w_flood  = ~(NUM_PORTS'(1) << r_port);
  assign w_onehot = NUM_PORTS'(1) << read_port_i;

  // The table has no miss signal: silence until the window closes means miss.
  assign w_hit  = (r_state == WAIT) && read_port_valid_i;
  assign w_miss = (r_state == WAIT) && !read_port_valid_i &&
                  (r_cnt == CW'(LOOKUP_LATENCY - 1));

  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    req_ready_o     = '0;
    learn_req_o     = 1'b0;
    learn_address_o = '0;
    learn_port_o    = '0;
    read_req_o      = 1'b0;
    read_address_o  = '0;
    fwd_valid_o     = 1'b0;
    fwd_mask_o      = '0;
    fwd_src_port_o  = '0;
    fwd_drop_o      = 1'b0;
    // Outputs are forced quiet while reset is held.
    if (!rst) begin
      case (r_state)
        IDLE: begin
          req_ready_o = w_grant;
          if (|w_grant) begin
            w_accept = 1'b1;
            w_next   = ISSUE;
          end
        end
        ISSUE: begin
          if (!is_group(r_sa)) begin
            learn_req_o     = 1'b1;
            learn_address_o = r_sa;
            learn_port_o    = r_port;
          end
          if (!is_group(r_da)) begin
            read_req_o     = 1'b1;
            read_address_o = r_da;
            w_next         = WAIT;
          end else begin
            w_next = RESP;
          end
        end
        WAIT: begin
          if (w_hit || w_miss) w_next = RESP;
        end
        RESP: begin
          fwd_valid_o    = 1'b1;
          fwd_mask_o     = r_mask;
          fwd_src_port_o = r_port;
          fwd_drop_o     = r_drop;
          if (fwd_ready_i) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_da    <= '0;
      r_sa    <= '0;
      r_port  <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_da   <= w_sel_da;
            r_sa   <= w_sel_sa;
            r_port <= w_gidx;
          end
        end
        // Preload flood: it is the answer for group DA and for a miss,
        // and a hit in WAIT overwrites it.
        ISSUE: begin
          r_cnt  <= '0;
          r_mask <= w_flood;
          r_drop <= 1'b0;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_hit) begin
            if (read_port_i == r_port) begin
              r_mask <= '0;
              r_drop <= 1'b1;
            end else begin
              r_mask <= w_onehot;
              r_drop <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_lookup_ctrl.sv
module tb_fwd_lookup_ctrl;
  import fwd_lookup_pkg::*;

  localparam int NP = 4;
  localparam int PW = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0]           req_valid_i;
  logic [NP-1:0]           req_ready_o;
  logic [NP*MAC_WIDTH-1:0] req_dst_addr_i;
  logic [NP*MAC_WIDTH-1:0] req_src_addr_i;
  logic                    learn_req_o;
  logic [MAC_WIDTH-1:0]    learn_address_o;
  logic [PW-1:0]           learn_port_o;
  logic                    read_req_o;
  logic [MAC_WIDTH-1:0]    read_address_o;
  logic [PW-1:0]           read_port_i;
  logic                    read_port_valid_i;
  logic                    fwd_valid_o;
  logic                    fwd_ready_i;
  logic [NP-1:0]           fwd_mask_o;
  logic [PW-1:0]           fwd_src_port_o;
  logic                    fwd_drop_o;

  fwd_lookup_ctrl #(.NUM_PORTS(NP), .LOOKUP_LATENCY(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_dst_addr_i    (req_dst_addr_i),
    .req_src_addr_i    (req_src_addr_i),
    .learn_req_o       (learn_req_o),
    .learn_address_o   (learn_address_o),
    .learn_port_o      (learn_port_o),
    .read_req_o        (read_req_o),
    .read_address_o    (read_address_o),
    .read_port_i       (read_port_i),
    .read_port_valid_i (read_port_valid_i),
    .fwd_valid_o       (fwd_valid_o),
    .fwd_ready_i       (fwd_ready_i),
    .fwd_mask_o        (fwd_mask_o),
    .fwd_src_port_o    (fwd_src_port_o),
    .fwd_drop_o        (fwd_drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          learn;
    logic [PW-1:0] lport;
    logic [47:0]   laddr;
    logic          rd;
    logic [47:0]   raddr;
  } req_exp_t;

  typedef struct {
    logic [NP-1:0] mask;
    logic          drop;
    logic [PW-1:0] src;
    int            lat;
  } dec_exp_t;

  typedef struct {
    logic          hit;
    logic [PW-1:0] port;
  } tbl_t;

  req_exp_t req_q[$];
  dec_exp_t dec_q[$];
  tbl_t     tbl_q[$];
  int       issue_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Table model: answers a read one cycle after the strobe, from tbl_q.
  logic          pend = 1'b0;
  logic [PW-1:0] pend_port = '0;
  tbl_t          rsp_t;
  initial begin
    read_port_valid_i = 1'b0;
    read_port_i       = '0;
    forever begin
      @(posedge clk);
      #1;
      read_port_valid_i = pend;
      read_port_i       = pend ? pend_port : '0;
      pend              = 1'b0;
      if (read_req_o && tbl_q.size() > 0) begin
        rsp_t     = tbl_q.pop_front();
        pend      = rsp_t.hit;
        pend_port = rsp_t.port;
      end
    end
  end

  // Request monitor: every learn/read strobe cycle is one ISSUE cycle.
  req_exp_t mon_re;
  always @(negedge clk) begin
    if (!rst && (learn_req_o || read_req_o)) begin
      issue_q.push_back(cyc);
      if (req_q.size() == 0) begin
        chk("req_unexpected", 1, 0);
      end else begin
        mon_re = req_q.pop_front();
        chk("learn_req",  learn_req_o,     mon_re.learn);
        chk("learn_port", learn_port_o,    mon_re.lport);
        chk("learn_addr", learn_address_o, mon_re.laddr);
        chk("read_req",   read_req_o,      mon_re.rd);
        chk("read_addr",  read_address_o,  mon_re.raddr);
      end
    end
  end

  // Decision monitor: latency on first valid, fields on handshake.
  dec_exp_t mon_de;
  int       mon_ic;
  logic     prev_vld = 1'b0;
  always @(negedge clk) begin
    if (fwd_valid_o && !prev_vld) begin
      if (issue_q.size() == 0 || dec_q.size() == 0) begin
        chk("fwd_lat_orphan", 1, 0);
      end else begin
        mon_ic = issue_q.pop_front();
        chk("fwd_latency", cyc - mon_ic, dec_q[0].lat);
      end
    end
    if (fwd_valid_o && fwd_ready_i) begin
      if (dec_q.size() == 0) begin
        chk("fwd_unexpected", 1, 0);
      end else begin
        mon_de = dec_q.pop_front();
        chk("fwd_mask", fwd_mask_o,     mon_de.mask);
        chk("fwd_drop", fwd_drop_o,     mon_de.drop);
        chk("fwd_src",  fwd_src_port_o, mon_de.src);
      end
    end
    prev_vld = fwd_valid_o;
  end

  task automatic push_exp(input int p, input logic [47:0] da, input logic [47:0] sa,
                          input logic [NP-1:0] mask, input logic drop, input int lat,
                          input logic with_dec, input logic thit, input logic [PW-1:0] tport);
    req_exp_t re;
    dec_exp_t de;
    tbl_t     te;
    re.learn = !sa[IG_BIT];
    re.lport = re.learn ? PW'(p) : '0;
    re.laddr = re.learn ? sa : '0;
    re.rd    = !da[IG_BIT];
    re.raddr = re.rd ? da : '0;
    req_q.push_back(re);
    if (re.rd) begin
      te.hit  = thit;
      te.port = tport;
      tbl_q.push_back(te);
    end
    if (with_dec) begin
      de.mask = mask;
      de.drop = drop;
      de.src  = PW'(p);
      de.lat  = lat;
      dec_q.push_back(de);
    end
  endtask

  task automatic present(input int p, input logic [47:0] da, input logic [47:0] sa);
    int n = 0;
    req_dst_addr_i[p*48 +: 48] = da;
    req_src_addr_i[p*48 +: 48] = sa;
    req_valid_i[p] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o[p] && n < 100);
    if (!req_ready_o[p]) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid_i[p] = 1'b0;
  endtask

  task automatic send(input int p, input logic [47:0] da, input logic [47:0] sa,
                      input logic thit, input logic [PW-1:0] tport,
                      input logic [NP-1:0] mask, input logic drop, input int lat);
    push_exp(p, da, sa, mask, drop, lat, 1'b1, thit, tport);
    present(p, da, sa);
  endtask

  task automatic set_all_bcast();
    for (int p = 0; p < NP; p++) begin
      req_dst_addr_i[p*48 +: 48] = BCAST_ADDR;
      req_src_addr_i[p*48 +: 48] = 48'h0000_0000_00A0 + 48'(p);
    end
  endtask

  task automatic push_bcast(input int p, input logic [NP-1:0] mask);
    push_exp(p, BCAST_ADDR, 48'h0000_0000_00A0 + 48'(p), mask, 1'b0, 1, 1'b1, 1'b0, '0);
  endtask

  task automatic rr_run(input int n);
    int acc = 0;
    int k = 0;
    while (acc < n && k < 300) begin
      @(negedge clk);
      k++;
      if (|req_ready_o) begin
        chk("grant_onehot", $countones(req_ready_o), 1);
        acc++;
      end
    end
    if (acc < n) chk("rr_timeout", acc, n);
    @(posedge clk);
    #1;
    req_valid_i = '0;
  endtask

  task automatic drain();
    int k = 0;
    while (dec_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (dec_q.size() != 0) chk("drain_timeout", dec_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, {req_ready_o, learn_req_o, learn_port_o, read_req_o, fwd_valid_o,
                       fwd_mask_o, fwd_src_port_o, fwd_drop_o}, 0);
    chk({nm, "_addr"}, {learn_address_o, read_address_o}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int k;
    rst            = 1'b1;
    req_valid_i    = '1;
    req_dst_addr_i = '0;
    req_src_addr_i = '0;
    fwd_ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    #1;
    chk("first_grant", req_ready_o, 4'b0001);
    req_valid_i = '0;

    // Unicast hit on another port.
    send(1, 48'h0011_2233_4455, 48'h00AA_0000_0001, 1'b1, 2'd2, 4'b0100, 1'b0, 2);
    // Unknown DA: table silent -> flood.
    send(0, 48'h0000_DEAD_BEEF, 48'h0000_0000_0010, 1'b0, 2'd0, 4'b1110, 1'b0, 2);
    // Broadcast DA: learn only, flood after one cycle.
    send(3, BCAST_ADDR, 48'h0000_0000_0033, 1'b0, 2'd0, 4'b0111, 1'b0, 1);

    // All ports requesting: grants 0,1,2,3,0.
    set_all_bcast();
    push_bcast(0, 4'b1110);
    push_bcast(1, 4'b1101);
    push_bcast(2, 4'b1011);
    push_bcast(3, 4'b0111);
    push_bcast(0, 4'b1110);
    req_valid_i = '1;
    rr_run(5);

    // Hit back to the ingress port: filtered.
    send(2, 48'h0000_0000_CAFE, 48'h0000_0000_0022, 1'b1, 2'd2, 4'b0000, 1'b1, 2);
    drain();

    // Scheduler stalls 5 cycles with all ports requesting; last grant was 2.
    fwd_ready_i = 1'b0;
    set_all_bcast();
    push_bcast(3, 4'b0111);
    push_bcast(0, 4'b1110);
    push_bcast(1, 4'b1101);
    push_bcast(2, 4'b1011);
    req_valid_i = '1;
    k = 0;
    while (!fwd_valid_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", fwd_valid_o, 1'b1);
      chk("stall_mask",  fwd_mask_o,  4'b0111);
      chk("stall_ready", req_ready_o, 4'b0000);
    end
    @(posedge clk);
    #1;
    fwd_ready_i = 1'b1;
    rr_run(3);

    // Group SA is never learned; lookup still proceeds.
    send(0, 48'h0000_0000_1234, 48'h0100_5E00_0001, 1'b1, 2'd3, 4'b1000, 1'b0, 2);
    drain();

    // Reset while waiting for the table: descriptor is abandoned.
    push_exp(1, 48'h0000_0000_5678, 48'h0000_0000_0011, 4'b0, 1'b0, 0, 1'b0, 1'b0, 2'd0);
    present(1, 48'h0000_0000_5678, 48'h0000_0000_0011);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    req_valid_i = '1;
    @(posedge clk);
    #1;
    chk_quiet("midreset");
    if (issue_q.size() > 0) void'(issue_q.pop_back());
    rst = 1'b0;
    #1;
    chk("post_reset_grant", req_ready_o, 4'b0001);
    req_valid_i = '0;
    repeat (6) @(posedge clk);
    #1;

    chk("req_q_left",   req_q.size(),   0);
    chk("dec_q_left",   dec_q.size(),   0);
    chk("tbl_q_left",   tbl_q.size(),   0);
    chk("issue_q_left", issue_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
